// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic-light sequencer: green/yellow/all-red rotation, optional walk phase (TRAFFIC_PED_EN).
// Latency: enable sampled at edge k lights green[0] from edge k+1; clear returns to IDLE on the next edge.
// Backpressure: none; lamp outputs are decoded from registered state only.
module traffic_phase_ctrl #(
  parameter int NUM_DIR    = 2,
  parameter int SEC_GREEN  = 10,
  parameter int SEC_YELLOW = 2,
  parameter int SEC_ALLRED = 1,
  parameter int SEC_WALK   = 5,
  parameter int DIV_FACTOR = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       continuous,
  input  logic                       ped_req,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic                       walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic                       done
);

  localparam int DIR_W  = $clog2(NUM_DIR);
  localparam int MAX_GY = (SEC_GREEN > SEC_YELLOW) ? SEC_GREEN : SEC_YELLOW;
  localparam int MAX_AW = (SEC_ALLRED > SEC_WALK) ? SEC_ALLRED : SEC_WALK;
  localparam int MAX_D  = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int CNT_W  = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  localparam int PRE_W  = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_WALK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ped_q, ped_d;

  logic               active;
  logic               tick;
  logic               phase_end;
  logic [CNT_W-1:0]   dur_m1;
  logic [NUM_DIR-1:0] dir_onehot;

`ifndef TRAFFIC_PED_EN
  // Pedestrian input has no function in this build.
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  // State, approach index, prescaler, phase counter and pedestrian latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
    end
  end

  // Tick generation and end-of-phase detection for the current state's duration.
  always_comb begin
    active = (state_q == S_GREEN) || (state_q == S_YELLOW) ||
             (state_q == S_ALLRED) || (state_q == S_WALK);
    tick   = active && (pre_q == PRE_W'(DIV_FACTOR - 1));
    dur_m1 = '0;
    case (state_q)
      S_GREEN:  dur_m1 = CNT_W'(SEC_GREEN - 1);
      S_YELLOW: dur_m1 = CNT_W'(SEC_YELLOW - 1);
      S_ALLRED: dur_m1 = CNT_W'(SEC_ALLRED - 1);
      S_WALK:   dur_m1 = CNT_W'(SEC_WALK - 1);
      default:  dur_m1 = '0;
    endcase
    phase_end = tick && (cnt_q == dur_m1);
  end

  // Next state, approach index, counters and latch; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_GREEN;
        dir_d   = '0;
      end
      S_GREEN:  if (phase_end) state_d = S_YELLOW;
      S_YELLOW: if (phase_end) state_d = S_ALLRED;
      S_ALLRED: if (phase_end) begin
        if (dir_q < DIR_W'(NUM_DIR - 1)) begin
          state_d = S_GREEN;
          dir_d   = dir_q + 1'b1;
        end else if (ped_q) begin
          state_d = S_WALK;
        end else if (continuous) begin
          state_d = S_GREEN;
          dir_d   = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WALK: if (phase_end) begin
        if (continuous) begin
          state_d = S_GREEN;
          dir_d   = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  if (clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      dir_d   = '0;
    end

    // Prescaler free-runs across phase changes so phases abut tick-exactly.
    if (active && (state_d != S_IDLE) && (state_d != S_DONE)) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end else begin
      pre_d = '0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

`ifdef TRAFFIC_PED_EN
    ped_d = ped_q | ped_req;
    if ((state_q == S_IDLE) || clear ||
        ((state_d == S_WALK) && (state_q != S_WALK))) begin
      ped_d = 1'b0;
    end
`else
    ped_d = 1'b0;
`endif
  end

  // Lamp and status decode from registered state.
  always_comb begin
    dir_onehot = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_q;
    red        = '1;
    yellow     = '0;
    green      = '0;
    if (state_q == S_GREEN) begin
      green = dir_onehot;
      red   = ~dir_onehot;
    end else if (state_q == S_YELLOW) begin
      yellow = dir_onehot;
      red    = ~dir_onehot;
    end
`ifdef TRAFFIC_PED_EN
    walk = (state_q == S_WALK);
`else
    walk = 1'b0;
`endif
    done       = (state_q == S_DONE);
    active_dir = dir_q;
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: timeline model of the rotation checked every cycle.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none.
module tb_traffic_phase_ctrl;
  localparam int ND = 2, SG = 3, SY = 2, SA = 1, SW = 2, DV = 4;
  localparam int SEG  = (SG + SY + SA) * DV;  // cycles per approach
  localparam int ROT  = ND * SEG;             // cycles per rotation
  localparam int WLEN = SW * DV;              // cycles of walk
`ifdef TRAFFIC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, enable, clear, continuous, ped_req;
  logic [ND-1:0] red, yellow, green;
  logic walk, done;
  logic [$clog2(ND)-1:0] active_dir;

  traffic_phase_ctrl #(
    .NUM_DIR(ND), .SEC_GREEN(SG), .SEC_YELLOW(SY), .SEC_ALLRED(SA),
    .SEC_WALK(SW), .DIV_FACTOR(DV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .continuous(continuous), .ped_req(ped_req), .red(red), .yellow(yellow),
    .green(green), .walk(walk), .active_dir(active_dir), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: mode 0 idle, 1 running, 2 done; m_t = cycles into the rotation.
  int m_mode;
  int m_t;
  bit m_walking;
  bit m_ped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_walking = 0; m_ped = 0;
  endtask

  task automatic model_next(input bit en, input bit clr, input bit cont, input bit preq);
    bit pnext;
    case (m_mode)
      0: begin
        m_ped = 0;
        if (en) begin m_mode = 1; m_t = 0; m_walking = 0; end
      end
      1: begin
        if (clr) begin
          m_mode = 0; m_ped = 0;
        end else begin
          pnext = PED ? (m_ped | preq) : 1'b0;
          if (!m_walking && m_t == ROT - 1) begin
            if (m_ped) begin m_walking = 1; m_t = ROT; pnext = 0; end
            else if (cont) m_t = 0;
            else m_mode = 2;
          end else if (m_walking && m_t == ROT + WLEN - 1) begin
            m_walking = 0;
            if (cont) m_t = 0; else m_mode = 2;
          end else begin
            m_t++;
          end
          m_ped = pnext;
        end
      end
      default: begin
        if (clr) begin m_mode = 0; m_ped = 0; end
        else m_ped = PED ? (m_ped | preq) : 1'b0;
      end
    endcase
  endtask

  task automatic compare();
    logic [ND-1:0] er, ey, eg;
    int d, r;
    er = '1; ey = '0; eg = '0; d = 0;
    if (m_mode == 1 && !m_walking) begin
      d = m_t / SEG;
      r = m_t % SEG;
      if (r < SG * DV) begin eg[d] = 1'b1; er[d] = 1'b0; end
      else if (r < (SG + SY) * DV) begin ey[d] = 1'b1; er[d] = 1'b0; end
      chk("active_dir", active_dir, d);
    end
    chk("red", red, er);
    chk("yellow", yellow, ey);
    chk("green", green, eg);
    chk("walk", walk, (m_mode == 1 && m_walking) ? 1 : 0);
    chk("done", done, (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step(input bit en, input bit clr, input bit cont, input bit preq);
    enable = en; clear = clr; continuous = cont; ped_req = preq;
    model_next(en, clr, cont, preq);
    @(posedge clk);
    #1;
    compare();
    cyc++;
  endtask

  initial begin
    int n, g0, y0, g1, y1, ar, wk, len;
    bit prev_g0, cont_r;
    int rises[$];

    rst_n = 1'b0; enable = 0; clear = 0; continuous = 0; ped_req = 0;
    model_reset();
    #12;
    chk("reset_red", red, 2'b11);
    chk("reset_green", green, 0);
    chk("reset_done", done, 0);
    compare();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single pass: phase lengths and done latency.
    step(1, 0, 0, 0);
    chk("s1_green0_rise", green, 2'b01);
    n = 0; g0 = 1; y0 = 0; g1 = 0; y1 = 0; ar = 0;
    while (!done && n < 200) begin
      step(0, 0, 0, 0);
      n++;
      if (green[0]) g0++;
      if (yellow[0]) y0++;
      if (green[1]) g1++;
      if (yellow[1]) y1++;
      if (red == 2'b11 && !done) ar++;
    end
    chk("s1_done_latency", n, 48);
    chk("s1_green0_len", g0, 12);
    chk("s1_yellow0_len", y0, 8);
    chk("s1_green1_len", g1, 12);
    chk("s1_yellow1_len", y1, 8);
    chk("s1_allred_len", ar, 8);

    // Clear from DONE, then restart.
    step(0, 1, 0, 0);
    chk("s2_done_cleared", done, 0);
    chk("s2_all_red", red, 2'b11);
    step(1, 0, 1, 0);
    chk("s2_restart_green0", green, 2'b01);
    chk("s2_restart_dir", active_dir, 0);

    // Continuous: green[0] rises every 48 cycles with no gap.
    prev_g0 = 1; rises.push_back(cyc); n = 0;
    for (int i = 0; i < 160; i++) begin
      step(0, 0, 1, 0);
      if (green[0] && !prev_g0) rises.push_back(cyc);
      if (done) n++;
      prev_g0 = green[0];
    end
    chk("s3_rise_count_ok", (rises.size() >= 3) ? 1 : 0, 1);
    if (rises.size() >= 3) begin
      chk("s3_period_a", rises[1] - rises[0], 48);
      chk("s3_period_b", rises[2] - rises[1], 48);
    end
    chk("s3_no_done", n, 0);

    // Clear mid-YELLOW of dir 1; fresh green[0] must be full length.
    n = 0;
    while (!yellow[1] && n < 100) begin step(0, 0, 1, 0); n++; end
    chk("s4_reached_yellow1", yellow, 2'b10);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("s4_idle_red", red, 2'b11);
    chk("s4_idle_yellow", yellow, 0);
    step(1, 0, 0, 0);
    len = 0;
    while (green[0] && len < 100) begin len++; step(0, 0, 0, 0); end
    chk("s4_green0_full", len, 12);

    // Asynchronous reset mid-GREEN.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s5_rst_red", red, 2'b11);
    chk("s5_rst_green", green, 0);
    chk("s5_rst_yellow", yellow, 0);
    chk("s5_rst_walk", walk, 0);
    chk("s5_rst_done", done, 0);
    chk("s5_rst_dir", active_dir, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pedestrian request during dir 0 green.
    step(1, 0, 0, 0);
    n = 0; wk = 0;
    while (!done && n < 200) begin
      step(0, 0, 0, (n == 1) ? 1'b1 : 1'b0);
      n++;
      if (walk) wk++;
    end
    chk("s6_done_latency", n, PED ? 56 : 48);
    chk("s6_walk_len", wk, PED ? 8 : 0);
    step(0, 1, 0, 0);

    // Randomized traffic against the model.
    cont_r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit en, clr, preq;
      if ($urandom_range(99) == 0) cont_r = ~cont_r;
      en   = ($urandom_range(3) == 0);
      clr  = (m_mode == 2) ? ($urandom_range(9) == 0) : ($urandom_range(149) == 0);
      preq = ($urandom_range(39) == 0);
      step(en, clr, cont_r, preq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-approach traffic-light sequencer, the successor to the single-approach yellow/green controller. It drives NUM_DIR approaches in strict rotation (green, yellow, all-red), with configurable phase durations, an internal 1-second tick prescaler and a single-pass or continuous mode. An optional pedestrian walk phase can be inserted at the end of each rotation. It sits between the board-level enable/clear controls and the lamp drivers.

## Interface
- NUM_DIR, 2: number of approaches; legal range 2..8.
- SEC_GREEN, 10: green duration in ticks; must be ≥1.
- SEC_YELLOW, 2: yellow duration in ticks; must be ≥1.
- SEC_ALLRED, 1: all-red clearance after each yellow, in ticks; must be ≥1.
- SEC_WALK, 5: walk duration in ticks (used only with TRAFFIC_PED_EN); must be ≥1.
- DIV_FACTOR, 10: clk cycles per tick; must be ≥1 (1 = tick every cycle).
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  starts a sequence; sampled only in IDLE.
- clear  in  1  returns the block to IDLE from any non-IDLE state.
- continuous  in  1  1 = loop rotations forever; 0 = stop in DONE after one rotation. Sampled at the end of each rotation.
- ped_req  in  1  pedestrian request pulse; latched.
- red  out  NUM_DIR  per-approach red lamp.
- yellow  out  NUM_DIR  per-approach yellow lamp.
- green  out  NUM_DIR  per-approach green lamp.
- walk  out  1  pedestrian walk lamp.
- active_dir  out  $clog2(NUM_DIR)  index of the approach currently in GREEN, YELLOW or ALLRED.
- done  out  1  high while in DONE.

## Operation
- States: IDLE, GREEN, YELLOW, ALLRED, WALK, DONE.
- Transitions:
  - IDLE → GREEN with dir=0 when enable=1.
  - GREEN → YELLOW after SEC_GREEN ticks.
  - YELLOW → ALLRED after SEC_YELLOW ticks.
  - ALLRED exit after SEC_ALLRED ticks:
    - if dir < NUM_DIR-1: GREEN with dir+1;
    - else if the pedestrian latch is set: WALK;
    - else if continuous=1: GREEN with dir=0;
    - else: DONE.
  - WALK → GREEN with dir=0 if continuous=1, else DONE, after SEC_WALK ticks.
  - DONE → IDLE when clear=1.
- clear=1 in GREEN, YELLOW, ALLRED or WALK aborts to IDLE on the next edge. clear takes priority over every other transition. clear in IDLE has no effect.
- Lamps:
  - green[dir]=1 only in GREEN; yellow[dir]=1 only in YELLOW.
  - Every other red bit is 1; red[dir]=0 in GREEN and YELLOW. All red bits are 1 in ALLRED, WALK, IDLE and DONE.
  - Exactly one lamp per approach is lit at all times.
- Outputs are decoded from registers only; there is no combinational path from any input to any output.
- Prescaler:
  - Counts 0..DIV_FACTOR-1 while in GREEN, YELLOW, ALLRED or WALK. tick=1 in the cycle the count equals DIV_FACTOR-1.
  - Held at 0 in IDLE and DONE.
  - Not reset on a phase change; phases abut tick-exactly.
- Phase counter: cleared on every state change. It increments on tick and the phase exits on the tick where it equals duration-1. Its width is sized from the largest duration parameter.

## Timing
- Reset values: state IDLE, red all ones, yellow=0, green=0, walk=0, done=0, active_dir=0, prescaler=0, phase counter=0, pedestrian latch=0.
- enable sampled high at edge k: green[0]=1 from edge k+1.
- Phase lengths in clk cycles: GREEN = SEC_GREEN·DIV_FACTOR, YELLOW = SEC_YELLOW·DIV_FACTOR, ALLRED = SEC_ALLRED·DIV_FACTOR, WALK = SEC_WALK·DIV_FACTOR.
- One single-pass rotation without walk lasts NUM_DIR·(SEC_GREEN+SEC_YELLOW+SEC_ALLRED)·DIV_FACTOR cycles. done rises on the next edge after the rotation ends.
- clear sampled at edge k: IDLE (all red, done=0) from edge k+1.
- active_dir changes on the same edge as the ALLRED→GREEN transition.

## Configuration
- Macro TRAFFIC_PED_EN.
- Defined:
  - ped_req=1 on any edge sets the pedestrian latch.
  - The latch is cleared on WALK entry, in IDLE, and by clear.
  - A request that arrives during WALK is kept for the next rotation.
- Undefined:
  - ped_req is ignored, walk is tied to 0 and WALK is unreachable.
  - Port list is unchanged.

## Test plan
All scenarios use NUM_DIR=2, SEC_GREEN=3, SEC_YELLOW=2, SEC_ALLRED=1, SEC_WALK=2, DIV_FACTOR=4.
- Reset release, then enable pulse at cycle 0 with continuous=0 → green[0] for 12 cycles, yellow[0] 8, all-red 4, then the same for dir 1; done=1 exactly 48 cycles after green[0] rose.
- In DONE, clear=1 → IDLE next cycle, done=0, all red; a further enable restarts at dir 0.
- continuous=1 → after dir 1 ALLRED, green[0] rises with no IDLE gap; the period is 48 cycles across 3 rotations.
- clear mid-YELLOW of dir 1 → IDLE next cycle. A new enable produces a full 12-cycle green[0], proving the prescaler was cleared.
- rst_n asserted mid-GREEN → all outputs at reset values immediately, asynchronously to clk.
- TRAFFIC_PED_EN defined, ped_req pulse during dir 0 GREEN → walk=1 for 8 cycles after dir 1 ALLRED, then DONE. With the macro undefined, the same stimulus gives walk=0 and done at 48 cycles.
